// File: rtl/fft_butterfly_engine_if.sv
// Sample-side bus of the butterfly engine: input pair handshake with its
// per-pair control, and the result handshake with X/Y and the saturation flag.
interface fft_butterfly_engine_if #(
   parameter int DATA_WIDTH  = 16,
   parameter int TOTAL_WIDTH = 8
);
   logic                   in_valid;
   logic                   in_ready;
   logic                   inverse;
   logic [TOTAL_WIDTH-1:0] j_index;
   logic [DATA_WIDTH-1:0]  a_in;
   logic [DATA_WIDTH-1:0]  b_in;
   logic                   out_valid;
   logic                   out_ready;
   logic [DATA_WIDTH-1:0]  x_out;
   logic [DATA_WIDTH-1:0]  y_out;
   logic                   sat;

   modport master (
      output in_valid, inverse, j_index, a_in, b_in, out_ready,
      input  in_ready, out_valid, x_out, y_out, sat
   );

   modport slave (
      input  in_valid, inverse, j_index, a_in, b_in, out_ready,
      output in_ready, out_valid, x_out, y_out, sat
   );
endinterface

// File: rtl/fft_butterfly_engine.sv
// Pipelined radix-2 DIT butterfly: X = A + W*B, Y = A - W*B.
// Computes the twiddle index, reads the factor back from an external
// combinational lookup one cycle later, and saturates the outputs.
// The whole pipe advances on a single enable, so a stalled output freezes
// every stage (including tw_index) and ordering is preserved.
module fft_butterfly_engine #(
   parameter int WIDTH       = 8,
   parameter int DATA_WIDTH  = 16,
   parameter int TOTAL_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [11:0]            SAMPLES,
   input  logic [3:0]             stage,
   output logic [TOTAL_WIDTH-1:0] tw_index,
   input  logic [WIDTH-1:0]       tw_data,
   output logic                   cfg_err,
   fft_butterfly_engine_if.slave  bus
);

   localparam int CW = WIDTH / 2;          // raw twiddle component width
   localparam int DW = DATA_WIDTH / 2;     // sample component width
   localparam int PW = DW + CW + 2;        // product-sum width
   localparam int SW = PW + 1;             // A +/- W*B full-precision width
   localparam int KW = TOTAL_WIDTH + 12;   // index product width

   localparam logic [CW-1:0]        TW_RAW_MIN = {1'b1, {(CW-1){1'b0}}};
   localparam logic signed [CW:0]   TW_ONE     = {2'b01, {(CW-1){1'b0}}};
   localparam logic signed [SW-1:0] SAT_HI     = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [SW-1:0] SAT_LO     = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   // The most negative raw code stands for +1.0 so that k = 0 gives W = 1 exactly.
   function automatic logic signed [CW:0] decode_tw(input logic [CW-1:0] raw);
      if (raw == TW_RAW_MIN) decode_tw = TW_ONE;
      else                   decode_tw = {raw[CW-1], raw};
   endfunction

   function automatic logic signed [DW-1:0] sat_fn(input logic signed [SW-1:0] v);
      if (v > SAT_HI)      sat_fn = SAT_HI[DW-1:0];
      else if (v < SAT_LO) sat_fn = SAT_LO[DW-1:0];
      else                 sat_fn = v[DW-1:0];
   endfunction

   function automatic logic ovf_fn(input logic signed [SW-1:0] v);
      ovf_fn = (v > SAT_HI) || (v < SAT_LO);
   endfunction

   logic en, accept;
   assign en          = !(bus.out_valid && !bus.out_ready);
   assign bus.in_ready = en;
   assign accept      = bus.in_valid && en;

   // Twiddle index k = (j mod span) * (N >> (s+1)); forced to 0 on an illegal stage.
   logic [4:0]             shamt;
   logic [16:0]            pow_s1;
   logic                   illegal;
   logic [TOTAL_WIDTH-1:0] j_mask;
   logic [11:0]            stride;
   logic [TOTAL_WIDTH-1:0] k_next;
   assign shamt   = {1'b0, stage} + 5'd1;
   assign pow_s1  = 17'd1 << shamt;
   assign illegal = pow_s1 > {5'd0, SAMPLES};
   assign j_mask  = bus.j_index & TOTAL_WIDTH'((17'd1 << stage) - 17'd1);
   assign stride  = SAMPLES >> shamt;
   assign k_next  = illegal ? '0 : TOTAL_WIDTH'(KW'(j_mask) * KW'(stride));

   logic [DATA_WIDTH-1:0]  a_p1, b_p1, a_p2, b_p2, a_p3;
   logic                   inv_p1;
   logic signed [CW:0]     c_p2, s_p2;
   logic signed [PW-1:0]   wr_p3, wi_p3;
   logic                   vld_p1, vld_p2, vld_p3;

   logic signed [CW:0] dec_cos, dec_sin;
   assign dec_cos = decode_tw(tw_data[CW-1:0]);
   assign dec_sin = decode_tw(tw_data[WIDTH-1:CW]);

   logic signed [DW-1:0] br2, bi2;
   logic signed [PW-1:0] wr_full, wi_full;
   assign br2     = b_p2[DW-1:0];
   assign bi2     = b_p2[DATA_WIDTH-1:DW];
   assign wr_full = PW'(br2) * PW'(c_p2) + PW'(bi2) * PW'(s_p2);
   assign wi_full = PW'(bi2) * PW'(c_p2) - PW'(br2) * PW'(s_p2);

   logic signed [DW-1:0] ar3, ai3;
   logic signed [SW-1:0] xr, xi, yr, yi;
   assign ar3 = a_p3[DW-1:0];
   assign ai3 = a_p3[DATA_WIDTH-1:DW];
   assign xr  = SW'(ar3) + SW'(wr_p3);
   assign xi  = SW'(ai3) + SW'(wi_p3);
   assign yr  = SW'(ar3) - SW'(wr_p3);
   assign yi  = SW'(ai3) - SW'(wi_p3);

   // Control, index and output registers: valid chain, tw_index, results, sticky cfg_err.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1        <= 1'b0;
         vld_p2        <= 1'b0;
         vld_p3        <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.sat       <= 1'b0;
         bus.x_out     <= '0;
         bus.y_out     <= '0;
         tw_index      <= '0;
         cfg_err       <= 1'b0;
      end else begin
         if (accept && illegal) cfg_err <= 1'b1;
         if (en) begin
            // P1: capture index of the accepted pair
            vld_p1 <= bus.in_valid;
            if (accept) tw_index <= k_next;
            // P2 -> P3 -> P4 valid chain
            vld_p2        <= vld_p1;
            vld_p3        <= vld_p2;
            bus.out_valid <= vld_p3;
            // P4: A +/- W*B with saturation
            if (vld_p3) begin
               bus.x_out <= {sat_fn(xi), sat_fn(xr)};
               bus.y_out <= {sat_fn(yi), sat_fn(yr)};
               bus.sat   <= ovf_fn(xr) | ovf_fn(xi) | ovf_fn(yr) | ovf_fn(yi);
            end
         end
      end
   end

   // Datapath registers, advanced by the shared enable.
   always_ff @(posedge clk) begin
      if (en) begin
         // P1: operands and direction
         a_p1   <= bus.a_in;
         b_p1   <= bus.b_in;
         inv_p1 <= bus.inverse;
         // P2: decoded twiddle, sin negated for the inverse transform
         a_p2 <= a_p1;
         b_p2 <= b_p1;
         c_p2 <= dec_cos;
         s_p2 <= inv_p1 ? -dec_sin : dec_sin;
         // P3: W*B with floor rounding
         a_p3  <= a_p2;
         wr_p3 <= wr_full >>> (CW - 1);
         wi_p3 <= wi_full >>> (CW - 1);
      end
   end

endmodule
